counter_cmd_seq: RTL and testbench
==================================

# counter_cmd_seq

Command sequencer that sits directly upstream of the 8-bit up/down counter and drives its `load`, `data_in`, `en` and `m` inputs. It accepts one command at a time over a valid/ready handshake: NOP, LOAD value, count UP N steps, or count DOWN N steps. It converts each command into the exact cycle-accurate control pattern, then reports completion with a one-cycle `done` pulse. Software and test sequencers use it to issue step-counted moves without per-cycle control.

## Interface
- `CNT_W`, 8, width of counter value, command argument and step counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  2  opcode: 00 NOP, 01 LOAD, 10 UP, 11 DOWN.
- `cmd_arg`  in  CNT_W  meaning depends on opcode:
  - LOAD: load value.
  - UP/DOWN: step count N.
  - NOP: ignored.
- `abort`  in  1  terminate the current UP/DOWN run.
- `cnt_load`  out  1  to counter `load`.
- `cnt_data`  out  CNT_W  to counter `data_in`.
- `cnt_en`  out  1  to counter `en`.
- `cnt_m`  out  1  to counter `m` (0 up, 1 down).
- `busy`  out  1  a command is executing (state ≠ IDLE).
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE:
    - `cmd_ready = !abort`.
    - Accept a command on `cmd_valid && cmd_ready` at the rising edge.
  - LOAD: one cycle with `cnt_load=1`.
  - RUN: `cnt_en=1` while remaining steps > 0.
- Transitions on acceptance:
  - NOP → IDLE, `done` pulse.
  - LOAD → LOAD.
  - UP/DOWN with N=0 → IDLE, `done` pulse.
  - UP/DOWN with N>0 → RUN, with `rem` = N and `cnt_m` set to `op[0]`.
- LOAD → IDLE unconditionally, `done` pulse. `abort` is ignored in LOAD.
- RUN:
  - `rem` decrements each cycle.
  - When `rem == 1` at an edge → IDLE with `done` pulse.
  - When `abort == 1` at an edge → IDLE with `done` pulse, remaining steps discarded.
- `cnt_data` is captured from `cmd_arg` on LOAD acceptance only, and holds otherwise.
- `cnt_m` holds its last value outside RUN.
- `cnt_load`, `cnt_en` and `done` are registered and never asserted simultaneously with one another except `done` is low whenever `cnt_load` or `cnt_en` is high.
- `cmd_arg` width rules:
  - Treated as unsigned.
  - N = 2^CNT_W−1 (255) yields exactly 255 enable cycles.
  - No wrap handling is needed here; counter wrap is the counter's concern.
- `cmd_op`/`cmd_arg` are sampled only in the acceptance cycle. Later changes have no effect.

## Timing
- Reset values:
  - `cnt_load`, `cnt_en`, `cnt_m`, `busy`, `done` = 0.
  - `cnt_data` = 0.
  - State = IDLE.
  - `cmd_ready` = 1 (with `abort` low).
- Command accepted at edge T:
  - LOAD: `cnt_load=1` in cycle T+1. `done=1` and `cmd_ready=1` in cycle T+2.
  - UP/DOWN N>0: `cnt_en=1` in cycles T+1 … T+N. `done=1` in T+N+1.
  - NOP or N=0: `done=1` in T+1. No `cnt_load`/`cnt_en` cycles.
- Abort:
  - `abort` high before edge A during RUN: `cnt_en` low from cycle A+1, `done=1` in A+1.
  - The counter sees exactly the RUN cycles up to and including cycle A.
- Back-to-back commands:
  - A new command may be accepted at the end of the `done` cycle.
  - Minimum gap between UP/DOWN runs is one idle cycle.
- `abort` in IDLE forces `cmd_ready=0` that cycle and has no other effect.
- `busy` = 1 exactly in LOAD and RUN cycles.
- Asynchronous reset mid-run: all outputs go to reset values immediately, state → IDLE, no `done`.

## Structure
- Package `counter_cmd_pkg`:
  - `op_t` enum (OP_NOP, OP_LOAD, OP_UP, OP_DOWN).
  - `state_t` enum (S_IDLE, S_LOAD, S_RUN).
  - Default `CNT_W`.
- Single module with no sub-module. The step counter is a local register, not a separate instance.
- Integration: `cnt_*` ports connect one-to-one to `updown_counter` on the same `clk`/`rst_n`.

## Test plan
- Reset released, idle 3 cycles → all outputs 0, `cmd_ready=1`, `done` never pulses.
- LOAD arg=0xA5 at T → `cnt_load=1`, `cnt_data=0xA5` at T+1. `done` at T+2. Downstream count = 0xA5.
- UP N=4 after LOAD 0xFE → `cnt_en` high 4 cycles, `cnt_m=0`, count 0xFE→0x02 via wrap. `done` at T+5.
- DOWN N=255 from 0x00 → exactly 255 enable cycles, final count 0x01, `done` at T+256.
- DOWN N=10, `abort` at 4th RUN cycle → 4 enable cycles, `done` next cycle. Next command accepted immediately.
- NOP and UP N=0 back-to-back → `done` at T+1 for each, no `cnt_en`. Assert `rst_n` mid-RUN → `cnt_en` drops asynchronously.

Source files
------------

// File: rtl/counter_cmd_pkg.sv
// Shared types for the up/down counter command sequencer.
package counter_cmd_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Valid/ready command channel into the counter command sequencer.
interface counter_cmd_seq_if #(
    parameter int CNT_W = counter_cmd_pkg::CNT_W
);
    import counter_cmd_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [CNT_W-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_seq.sv
// Turns NOP/LOAD/UP N/DOWN N commands into cycle-exact load/en/m control for an
// 8-bit up/down counter, with a one-cycle done pulse per command.
module counter_cmd_seq
    import counter_cmd_pkg::*;
#(
    parameter int CNT_W = counter_cmd_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    counter_cmd_seq_if.slave   cmd,
    input  logic               abort,
    output logic               cnt_load,
    output logic [CNT_W-1:0]   cnt_data,
    output logic               cnt_en,
    output logic               cnt_m,
    output logic               busy,
    output logic               done
);

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             accept;

    // Abort in IDLE only masks readiness; it never reaches the state machine there.
    assign cmd.cmd_ready = (state == S_IDLE) && !abort;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rem      <= '0;
            cnt_load <= 1'b0;
            cnt_data <= '0;
            cnt_en   <= 1'b0;
            cnt_m    <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking default first; a later assignment in the same cycle wins,
            // so done is a single-cycle pulse without any extra clear logic.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_NOP: begin
                                done <= 1'b1;
                            end
                            OP_LOAD: begin
                                state    <= S_LOAD;
                                cnt_load <= 1'b1;
                                cnt_data <= cmd.cmd_arg;
                            end
                            OP_UP, OP_DOWN: begin
                                if (cmd.cmd_arg == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    state  <= S_RUN;
                                    rem    <= cmd.cmd_arg;
                                    cnt_en <= 1'b1;
                                    cnt_m  <= cmd.cmd_op[0];
                                end
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    state    <= S_IDLE;
                    cnt_load <= 1'b0;
                    done     <= 1'b1;
                end
                S_RUN: begin
                    // rem counts enable cycles still owed, including the current one.
                    if (abort || rem == CNT_W'(1)) begin
                        state  <= S_IDLE;
                        rem    <= '0;
                        cnt_en <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt_load <= 1'b0;
                    cnt_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Self-checking bench: directed command table, random commands against a
// command-level trace model, async reset mid-run.
module tb_counter_cmd_seq;
    import counter_cmd_pkg::*;

    localparam int W = CNT_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         cnt_load, cnt_en, cnt_m, busy, done;
    logic [W-1:0] cnt_data;

    counter_cmd_seq_if #(.CNT_W(W)) cmd_bus ();

    counter_cmd_seq #(.CNT_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd_bus),
        .abort    (abort),
        .cnt_load (cnt_load),
        .cnt_data (cnt_data),
        .cnt_en   (cnt_en),
        .cnt_m    (cnt_m),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream up/down counter.
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        count <= '0;
        else if (cnt_load) count <= cnt_data;
        else if (cnt_en)   count <= cnt_m ? count - 1'b1 : count + 1'b1;
    end

    int vectors = 0;
    int miscompares = 0;

    logic         exp_m = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic [W-1:0] exp_count = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return 32'({cmd_bus.cmd_ready, busy, done, cnt_load, cnt_en, cnt_m, cnt_data});
    endfunction

    function automatic logic [31:0] expv(input logic rdy, input logic bsy, input logic dn,
                                         input logic ld, input logic en);
        return 32'({rdy, bsy, dn, ld, en, exp_m, exp_data});
    endfunction

    // Issue one command in the current (idle) cycle and check every cycle up to done.
    // abort_at = k > 0 raises abort during the k-th RUN cycle.
    task automatic issue(input op_t op, input logic [W-1:0] arg, input int abort_at,
                         input string tag);
        logic [1:0] opb;
        logic       is_run, is_load;
        int         n_en, len;
        logic       e_busy, e_done, e_ld, e_en;
        opb     = op;
        is_load = (op == OP_LOAD);
        is_run  = (op == OP_UP || op == OP_DOWN) && (arg != '0);

        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_arg   = arg;
        abort             = 1'b0;
        #1 check({tag, ":ready"}, 32'(cmd_bus.cmd_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        // Garbage after acceptance must be ignored.
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = op_t'($urandom_range(0, 3));
        cmd_bus.cmd_arg   = W'($urandom);

        n_en = 0;
        if (is_run) begin
            n_en  = (abort_at > 0 && abort_at < int'(arg)) ? abort_at : int'(arg);
            exp_m = opb[0];
        end
        if (is_load) exp_data = arg;
        len = is_load ? 2 : (is_run ? n_en + 1 : 1);

        for (int j = 1; j <= len; j++) begin
            abort  = is_run && (j == abort_at);
            e_ld   = is_load && (j == 1);
            e_en   = is_run && (j <= n_en);
            e_busy = e_ld || e_en;
            e_done = (j == len);
            #1 check($sformatf("%s:cyc%0d", tag, j), obs(),
                     expv(!e_busy && !abort, e_busy, e_done, e_ld, e_en));
            if (j < len) @(negedge clk);
        end
        abort = 1'b0;

        if (is_load)     exp_count = arg;
        else if (is_run) exp_count = exp_m ? exp_count - W'(n_en) : exp_count + W'(n_en);
        check({tag, ":count"}, 32'(count), 32'(exp_count));
    endtask

    task automatic idle_cycles(input int n, input bit allow_abort);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            abort = allow_abort ? 1'($urandom_range(0, 1)) : 1'b0;
            #1 check("idle", obs(), expv(!abort, 1'b0, 1'b0, 1'b0, 1'b0));
            abort = 1'b0;
        end
    endtask

    typedef struct {
        op_t          op;
        logic [W-1:0] arg;
        int           abort_at;
        logic [W-1:0] count;
        string        name;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{OP_LOAD, 8'hA5,   0, 8'hA5, "load_a5"};
        tbl[1] = '{OP_LOAD, 8'hFE,   0, 8'hFE, "load_fe"};
        tbl[2] = '{OP_UP,   8'd4,    0, 8'h02, "up4_wrap"};
        tbl[3] = '{OP_LOAD, 8'h00,   0, 8'h00, "load_00"};
        tbl[4] = '{OP_DOWN, 8'd255,  0, 8'h01, "down255"};
        tbl[5] = '{OP_DOWN, 8'd10,   4, 8'hFD, "down10_abort4"};
        tbl[6] = '{OP_NOP,  8'h77,   0, 8'hFD, "nop"};
        tbl[7] = '{OP_UP,   8'd0,    0, 8'hFD, "up0"};
        tbl[8] = '{OP_UP,   8'd1,    0, 8'hFE, "up1"};
        tbl[9] = '{OP_DOWN, 8'd3,    3, 8'hFB, "down3_abort_last"};

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = OP_NOP;
        cmd_bus.cmd_arg   = '0;

        #1 check("reset", obs(), expv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3, 1'b0);

        // Directed table, issued back-to-back.
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].arg, tbl[i].abort_at, tbl[i].name);
            check({tbl[i].name, ":table_count"}, 32'(count), 32'(tbl[i].count));
        end
        idle_cycles(2, 1'b1);

        // Random commands with random gaps and idle-time aborts.
        for (int r = 0; r < 60; r++) begin
            op_t          op;
            logic [W-1:0] arg;
            int           ab;
            op = op_t'($urandom_range(0, 3));
            if (op == OP_LOAD || $urandom_range(0, 9) == 0) arg = W'($urandom);
            else                                             arg = W'($urandom_range(0, 12));
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (arg > 0) ? int'(arg) : 1) : 0;
            issue(op, arg, ab, $sformatf("rnd%0d", r));
            idle_cycles($urandom_range(0, 2), 1'b1);
        end

        // Asynchronous reset in the middle of a run.
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_UP;
        cmd_bus.cmd_arg   = 8'd20;
        @(posedge clk);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("midrun_en", 32'({busy, cnt_en}), 32'(2'b11));
        #2 rst_n = 1'b0;
        exp_m     = 1'b0;
        exp_data  = '0;
        exp_count = '0;
        #1 check("async_reset", obs(), expv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        check("async_reset_count", 32'(count), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2, 1'b0);
        issue(OP_LOAD, 8'h3C, 0, "post_reset_load");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
